// File: rtl/md_hazard_ctrl_pkg.sv
// Shared constants, slot payload types and comparator helpers for the MDU-side
// hazard controller. Imported by md_hazard_slot and md_hazard_ctrl.
package md_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned FWD_W  = 2;

    // Tuse value meaning "operand not read by this instruction"
    localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

    // Forwarding source selects
    localparam logic [FWD_W-1:0] FWD_RF = 2'd0;
    localparam logic [FWD_W-1:0] FWD_M  = 2'd1;
    localparam logic [FWD_W-1:0] FWD_W_SEL = 2'd2;

    // Destination shadow carried by every pipeline slot
    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [TNEW_W-1:0] tnew;
    } slot_t;

    // Extra operand info held only for the E-stage instruction
    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              muldiv;
    } e_ops_t;

    // Operand a is needed before a producer in E or M can supply it
    function automatic logic raw_hazard(input logic [REG_AW-1:0] a,
                                        input logic [TNEW_W-1:0] tuse,
                                        input slot_t             e,
                                        input slot_t             m);
        return (a != '0) &&
               (((e.wa == a) && (e.tnew > tuse)) ||
                ((m.wa == a) && (m.tnew > tuse)));
    endfunction

    // Younger ready producer (M) wins over W; $0 is never forwarded
    function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_AW-1:0] a,
                                                 input slot_t             m,
                                                 input slot_t             w);
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if ((a != '0) && (m.wa == a) && (m.tnew == '0)) begin
            sel = FWD_M;
        end else if ((a != '0) && (w.wa == a)) begin
            sel = FWD_W_SEL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_hazard_slot.sv
// One pipeline slot shadow register (wa, tnew).
// Ports: clk, reset (sync, active-high), bubble (load an empty slot),
//        din (incoming slot), q (registered slot).
// DEC selects a saturating tnew decrement as the instruction moves in.
module md_hazard_slot
    import md_hazard_ctrl_pkg::*;
#(
    parameter bit DEC = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  bubble,
    input  slot_t din,
    output slot_t q
);

    // Slot register; tnew counts down to 0 and stays there
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            q <= '0;
        end else if (DEC && (din.tnew != '0)) begin
            q.wa   <= din.wa;
            q.tnew <= din.tnew - TNEW_W'(1);
        end else begin
            q <= din;
        end
    end

endmodule

// File: rtl/md_hazard_ctrl.sv
// Hazard/stall controller upstream of the MDU in the D->E->M->W pipeline.
// Ports:
//   clk, reset (sync, active-high), req (flush request)
//   d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew, d_is_md, d_is_muldiv : D-stage info
//   mdu_busy : MDU busy
//   stall    : freeze PC/FD and bubble E (combinational)
//   md_start : one-cycle MDU start for the mul/div in E (combinational)
//   fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e : forward selects (0 RF/E reg, 1 M, 2 W)
module md_hazard_ctrl
    import md_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_AW-1:0] d_wa,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_is_md,
    input  logic              d_is_muldiv,
    input  logic              mdu_busy,
    output logic              stall,
    output logic              md_start,
    output logic [FWD_W-1:0]  fwd_rs_d,
    output logic [FWD_W-1:0]  fwd_rt_d,
    output logic [FWD_W-1:0]  fwd_rs_e,
    output logic [FWD_W-1:0]  fwd_rt_e
);

    slot_t  d_slot;
    slot_t  e_q;
    slot_t  m_q;
    slot_t  w_q;
    e_ops_t e_ops_q;
    logic   e_bubble;

    assign d_slot   = {d_wa, d_tnew};
    // stall already excludes req, so a flush never adds an extra bubble cycle
    assign e_bubble = req | stall;

    md_hazard_slot #(.DEC(1'b0)) u_slot_e (
        .clk    (clk),
        .reset  (reset),
        .bubble (e_bubble),
        .din    (d_slot),
        .q      (e_q)
    );

    md_hazard_slot #(.DEC(1'b1)) u_slot_m (
        .clk    (clk),
        .reset  (reset),
        .bubble (req),
        .din    (e_q),
        .q      (m_q)
    );

    md_hazard_slot #(.DEC(1'b1)) u_slot_w (
        .clk    (clk),
        .reset  (reset),
        .bubble (req),
        .din    (m_q),
        .q      (w_q)
    );

    // E-stage operand addresses and mul/div flag, bubbled with the E slot
    always_ff @(posedge clk) begin
        if (reset || e_bubble) begin
            e_ops_q <= '0;
        end else begin
            e_ops_q <= {d_rs, d_rt, d_is_muldiv};
        end
    end

    // W tnew is always drained by the time it matters; kept only for slot symmetry
    logic unused_w_tnew;
    assign unused_w_tnew = ^w_q.tnew;

    // Stall, MDU start and forwarding selects
    always_comb begin
        md_start = 1'b0;
        stall    = 1'b0;
        fwd_rs_d = FWD_RF;
        fwd_rt_d = FWD_RF;
        fwd_rs_e = FWD_RF;
        fwd_rt_e = FWD_RF;

        md_start = e_ops_q.muldiv && !req;
        stall    = !req &&
                   (raw_hazard(d_rs, d_tuse_rs, e_q, m_q) ||
                    raw_hazard(d_rt, d_tuse_rt, e_q, m_q) ||
                    (d_is_md && (mdu_busy || md_start)));

        fwd_rs_d = fwd_sel(d_rs, m_q, w_q);
        fwd_rt_d = fwd_sel(d_rt, m_q, w_q);
        fwd_rs_e = fwd_sel(e_ops_q.rs, m_q, w_q);
        fwd_rt_e = fwd_sel(e_ops_q.rt, m_q, w_q);
    end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Self-checking bench for md_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against an in-flight instruction model.
module tb_md_hazard_ctrl;
    import md_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req, d_is_md, d_is_muldiv, mdu_busy;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       stall, md_start;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    md_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_wa        (d_wa),
        .d_tnew      (d_tnew),
        .d_is_md     (d_is_md),
        .d_is_muldiv (d_is_muldiv),
        .mdu_busy    (mdu_busy),
        .stall       (stall),
        .md_start    (md_start),
        .fwd_rs_d    (fwd_rs_d),
        .fwd_rt_d    (fwd_rt_d),
        .fwd_rs_e    (fwd_rs_e),
        .fwd_rt_e    (fwd_rt_e)
    );

    // Next-cycle input set, applied at the falling edge
    typedef struct {
        logic       reset, req, md, mdv, busy;
        logic [4:0] rs, rt, wa;
        logic [1:0] tus, tut, tn;
    } in_t;
    in_t nx;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    // Each in-flight instruction keeps the tnew it had when it entered E;
    // at stage k (0=E,1=M,2=W) its remaining latency is max(0, tnew0-k).
    typedef struct {
        int wa;
        int tnew0;
        int rs;
        int rt;
        bit muldiv;
    } ent_t;
    ent_t pipe[3];
    bit   mvalid = 1'b0;

    function automatic int rem(int k);
        return (pipe[k].tnew0 > k) ? pipe[k].tnew0 - k : 0;
    endfunction

    function automatic bit needs_wait(int a, int tuse);
        if (a == 0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wa == a && rem(k) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int src_of(int a);
        if (a == 0) return 0;
        if (pipe[1].wa == a && rem(1) == 0) return 1;
        if (pipe[2].wa == a) return 2;
        return 0;
    endfunction

    function automatic bit exp_start();
        return pipe[0].muldiv && !req;
    endfunction

    function automatic bit exp_stall();
        return !req && (needs_wait(int'(d_rs), int'(d_tuse_rs)) ||
                        needs_wait(int'(d_rt), int'(d_tuse_rt)) ||
                        (d_is_md && (mdu_busy || exp_start())));
    endfunction

    function automatic void flush_model();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 1'b0};
    endfunction

    always @(posedge clk) begin
        bit st;
        st = exp_stall();
        if (reset) begin
            flush_model();
            mvalid = 1'b1;
        end else if (req) begin
            flush_model();
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st) pipe[0] = '{0, 0, 0, 0, 1'b0};
            else    pipe[0] = '{int'(d_wa), int'(d_tnew), int'(d_rs), int'(d_rt), d_is_muldiv};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_cmp();
        if (!mvalid) return;
        check("stall",    32'(stall),    32'(exp_stall()));
        check("md_start", 32'(md_start), 32'(exp_start()));
        check("fwd_rs_d", 32'(fwd_rs_d), 32'(src_of(int'(d_rs))));
        check("fwd_rt_d", 32'(fwd_rt_d), 32'(src_of(int'(d_rt))));
        check("fwd_rs_e", 32'(fwd_rs_e), 32'(src_of(pipe[0].rs)));
        check("fwd_rt_e", 32'(fwd_rt_e), 32'(src_of(pipe[0].rt)));
    endtask

    // One cycle: drive nx at the falling edge, compare after settling
    task automatic cyc();
        @(negedge clk);
        reset       = nx.reset;
        req         = nx.req;
        d_is_md     = nx.md;
        d_is_muldiv = nx.mdv;
        mdu_busy    = nx.busy;
        d_rs        = nx.rs;
        d_rt        = nx.rt;
        d_wa        = nx.wa;
        d_tuse_rs   = nx.tus;
        d_tuse_rt   = nx.tut;
        d_tnew      = nx.tn;
        #1;
        model_cmp();
    endtask

    task automatic idle();
        nx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 2'd0};
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tus, input logic [1:0] tut,
                         input logic [4:0] wa, input logic [1:0] tn,
                         input logic md, input logic mdv);
        nx.rs = rs; nx.rt = rt; nx.tus = tus; nx.tut = tut;
        nx.wa = wa; nx.tn = tn; nx.md = md; nx.mdv = mdv;
    endtask

    task automatic drain();
        idle();
        repeat (3) cyc();
    endtask

    task automatic all_quiet(input string tag);
        check({tag, "_stall"},    32'(stall),    32'd0);
        check({tag, "_md_start"}, 32'(md_start), 32'd0);
        check({tag, "_fwd"},      32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}), 32'd0);
    endtask

    initial begin
        int nstall;
        int nstart;
        flush_model();
        idle();
        nx.reset = 1'b1;
        repeat (2) cyc();
        idle();
        cyc();
        all_quiet("reset_state");

        // 1: lw $1 then add using $1 with tuse 1
        drain();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd1, 2'd2, 1'b0, 1'b0); cyc();
        set_d(5'd1, 5'd0, 2'd1, TUSE_NONE, 5'd3, 2'd1, 1'b0, 1'b0);      cyc();
        check("t1_stall_on", 32'(stall), 32'd1);
        cyc();
        check("t1_stall_off", 32'(stall), 32'd0);
        idle(); cyc();
        check("t1_fwd_rs_e_w", 32'(fwd_rs_e), 32'd2);

        // 2: add $2 then beq $2 with tuse 0
        drain();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd2, 2'd1, 1'b0, 1'b0); cyc();
        set_d(5'd2, 5'd0, 2'd0, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0);      cyc();
        check("t2_stall_on", 32'(stall), 32'd1);
        cyc();
        check("t2_stall_off", 32'(stall), 32'd0);
        check("t2_fwd_rs_d_m", 32'(fwd_rs_d), 32'd1);

        // 3: mult then mflo with MDU busy for 5 cycles
        drain();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b1, 1'b1); cyc();
        check("t3_mult_d_stall", 32'(stall), 32'd0);
        nstall = 0;
        nstart = 0;
        for (int i = 0; i < 7; i++) begin
            set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd4, 2'd1, 1'b1, 1'b0);
            nx.busy = (i >= 1 && i <= 5);
            cyc();
            if (i == 0) check("t3_start_first", 32'(md_start), 32'd1);
            nstall += int'(stall);
            nstart += int'(md_start);
        end
        check("t3_stall_cycles", 32'(nstall), 32'd6);
        check("t3_start_cycles", 32'(nstart), 32'd1);

        // 4: M and W both write $5, D reads $5
        drain();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, 2'd1, 1'b0, 1'b0); cyc();
        cyc();
        idle(); cyc();
        set_d(5'd5, 5'd5, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0); cyc();
        check("t4_fwd_rs_d_mprio", 32'(fwd_rs_d), 32'd1);
        check("t4_fwd_rt_d_mprio", 32'(fwd_rt_d), 32'd1);
        idle(); cyc();
        check("t4_zero_stall", 32'(stall), 32'd0);
        check("t4_zero_fwd", 32'(fwd_rs_d), 32'd0);

        // 5: req while stalled with mult in E
        drain();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd7, 2'd1, 1'b0, 1'b0); cyc();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b1, 1'b1); cyc();
        set_d(5'd7, 5'd0, TUSE_NONE, TUSE_NONE, 5'd4, 2'd1, 1'b1, 1'b0);
        nx.req = 1'b1;
        cyc();
        check("t5_req_stall", 32'(stall), 32'd0);
        check("t5_req_start", 32'(md_start), 32'd0);
        idle();
        set_d(5'd7, 5'd7, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0);
        cyc();
        all_quiet("t5_flushed");

        // 6: reset asserted mid-stall
        drain();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd1, 2'd2, 1'b0, 1'b0); cyc();
        set_d(5'd1, 5'd0, 2'd1, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0);
        nx.reset = 1'b1;
        cyc();
        check("t6_stall_before", 32'(stall), 32'd1);
        nx.reset = 1'b0;
        cyc();
        all_quiet("t6_after_reset");

        // Randomized traffic
        idle();
        for (int i = 0; i < 3000; i++) begin
            nx.reset = ($urandom_range(0, 99) == 0);
            nx.req   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 4) == 0) nx.busy = ~nx.busy;
            nx.rs  = 5'($urandom_range(0, 3));
            nx.rt  = 5'($urandom_range(0, 3));
            nx.wa  = 5'($urandom_range(0, 3));
            nx.tus = 2'($urandom_range(0, 3));
            nx.tut = 2'($urandom_range(0, 3));
            nx.tn  = 2'($urandom_range(0, 3));
            nx.mdv = ($urandom_range(0, 5) == 0);
            nx.md  = nx.mdv | ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
